dq_lane_cal: RTL
================

DQ_LANE_CAL -- requirements
Module: dq_lane_cal

Interface
REQ-001 SHALL have parameter WIDTH, default 8: DQ bits per lane, calibrated one bit at a time.
REQ-002 SHALL have parameter TAPS, default 64: IDELAY tap count; tap index width is clog2(TAPS).
REQ-003 SHALL have parameter SAMPLES, default 16: compare cycles per tap.
REQ-004 SHALL have parameter SETTLE, default 4: wait cycles after any delay change before sampling.
REQ-005 SHALL have parameters EXP_Q1 and EXP_Q2, defaults 1 and 0: expected training-pattern value per ISERDES output.
REQ-006 SHALL have MCLK90, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have ResetN, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have Start, input, 1 bit: a one-cycle pulse that begins calibration.
REQ-009 SHALL have IserdesQ1, input, WIDTH bits: low-order captured bit per DQ.
REQ-010 SHALL have IserdesQ2, input, WIDTH bits: high-order captured bit per DQ.
REQ-011 SHALL have DlyInc, output, WIDTH bits: per-bit IDELAY CE/INC pulse.
REQ-012 SHALL have DlyReset, output, WIDTH bits: per-bit IDELAY reset pulse.
REQ-013 SHALL have Busy, output, 1 bit: calibration in progress.
REQ-014 SHALL have Done, output, 1 bit: calibration complete; held until the next Start.
REQ-015 SHALL have Fail, output, WIDTH bits: set for each bit that had no passing tap.

Function
REQ-016 SHALL implement FSM states IDLE, RST, SETTLE, SAMPLE, EVAL, STEP, CRST, CSETTLE, CINC, NEXT and DONE.
REQ-017 IDLE with Start=1 SHALL: clear Done and Fail, set bit index b=0 and tap=0, assert Busy, and go to RST.
REQ-018 RST SHALL pulse DlyReset[b] for exactly 1 cycle and then go to SETTLE.
REQ-019 SETTLE SHALL wait SETTLE cycles and then go to SAMPLE.
REQ-020 SAMPLE SHALL run for SAMPLES cycles; the tap passes only if IserdesQ1[b]==EXP_Q1 and IserdesQ2[b]==EXP_Q2 on every one of those cycles.
REQ-021 EVAL SHALL track only the first contiguous passing window.
- On the first pass: lo=tap.
- On each pass while the window is open: hi=tap.
- On a fail after a pass: the window is closed.
REQ-022 STEP SHALL, if tap<TAPS-1, pulse DlyInc[b] for 1 cycle, increment tap, and go to SETTLE; otherwise it SHALL go to CRST.
REQ-023 The center tap SHALL be c=(lo+hi)>>1, computed with a width of clog2(TAPS)+1 bits so that the sum cannot overflow.
REQ-024 CRST SHALL pulse DlyReset[b] for 1 cycle.
REQ-025 CINC SHALL pulse DlyInc[b] on c consecutive cycles; c=0 SHALL produce no pulses.
REQ-026 After CINC, CSETTLE SHALL wait SETTLE cycles and then go to NEXT.
REQ-027 If bit b had no passing tap, the block SHALL set Fail[b], pulse DlyReset[b] only (leaving tap 0), and go to NEXT.
REQ-028 NEXT SHALL go to RST with b+1 if b<WIDTH-1, otherwise to DONE.
REQ-029 DONE SHALL, for 1 cycle, set Done=1 and Busy=0, then go to IDLE; Done SHALL stay set in IDLE.
REQ-030 Start while Busy SHALL be ignored.
REQ-031 Only bit b SHALL ever see DlyInc or DlyReset asserted; DlyInc and DlyReset SHALL never be asserted in the same cycle.
REQ-032 A window that stays open at tap TAPS-1 SHALL close with hi=TAPS-1.

Reset
REQ-033 ResetN=0 SHALL asynchronously force the following, from any state including mid-sweep:
- state=IDLE;
- DlyInc=0, DlyReset=0, Busy=0, Done=0, Fail=0;
- b, tap, lo, hi and all counters to 0.
REQ-034 Release of ResetN SHALL take effect on the next MCLK90 edge, and the FSM SHALL then wait in IDLE for Start.

Configuration
REQ-035 The block SHALL support the macro DQ_CAL_EARLY_EXIT_EN.
- Defined: EVAL, on window close, SHALL go directly to CRST, skipping the remaining taps.
- Undefined: the sweep SHALL always cover all TAPS taps.
- Both modes SHALL yield identical lo, hi, c and Fail; they SHALL differ only in cycle count.

Verification
REQ-036 The bench SHALL cover these directed scenarios, with WIDTH=2, TAPS=64, SAMPLES=4, SETTLE=2 unless stated:
- Scenario 1: bit0 passes taps 10..20, bit1 passes taps 30..33 -> bit0 gets 15 DlyInc pulses after its CRST, bit1 gets 31 DlyInc pulses after its CRST, Fail=00, and Done rises.
- Scenario 2: bit1 never passes -> Fail=10, bit1 sees only DlyReset pulses and 0 centering DlyInc pulses, and Done=1.
- Scenario 3: passing window 60..63 -> c=61, with no overflow.
- Scenario 4: windows at taps 5..7 and 40..50 -> c=6, so the second window is ignored.
- Scenario 5: ResetN=0 at tap 25 of bit0 -> all outputs are 0 immediately, and a new Start restarts at b=0, tap=0.
- Scenario 6: window 10..20 -> with DQ_CAL_EARLY_EXIT_EN, bit0 reaches CRST after 22 taps are evaluated (taps 0..21); without it, after 64 taps; c=15 in both cases.

Source files
------------

// File: rtl/dq_lane_cal.sv
// Per-bit DQ read-capture calibration: sweeps IDELAY taps one DQ bit at a time
// and centers each bit in its first passing window. Optional DQ_CAL_EARLY_EXIT_EN.
module dq_lane_cal #(
  parameter int   WIDTH   = 8,
  parameter int   TAPS    = 64,
  parameter int   SAMPLES = 16,
  parameter int   SETTLE  = 4,
  parameter logic EXP_Q1  = 1'b1,
  parameter logic EXP_Q2  = 1'b0
) (
  input  logic             MCLK90,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [WIDTH-1:0] IserdesQ1,
  input  logic [WIDTH-1:0] IserdesQ2,
  output logic [WIDTH-1:0] DlyInc,
  output logic [WIDTH-1:0] DlyReset,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Fail
);

  localparam int TW   = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CMAX = (TAPS > SETTLE) ? ((TAPS > SAMPLES) ? TAPS : SAMPLES)
                                        : ((SETTLE > SAMPLES) ? SETTLE : SAMPLES);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP,
    S_CRST, S_CSETTLE, S_CINC, S_NEXT, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    b_q, b_d;
  logic [TW-1:0]    tap_q, tap_d, lo_q, lo_d, hi_q, hi_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pass_q, pass_d, found_q, found_d, open_q, open_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] fail_q, fail_d;

  logic [TW:0]      sum, c;
  logic             match;

  // One extra bit so lo+hi near the top of the tap range cannot wrap.
  assign sum   = {1'b0, lo_q} + {1'b0, hi_q};
  assign c     = sum >> 1;
  assign match = (IserdesQ1[b_q] == EXP_Q1) && (IserdesQ2[b_q] == EXP_Q2);

  assign Done = done_q;
  assign Fail = fail_q;

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    tap_d    = tap_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    found_d  = found_q;
    open_d   = open_q;
    done_d   = done_q;
    fail_d   = fail_q;
    DlyInc   = '0;
    DlyReset = '0;
    Busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    case (state_q)
      S_IDLE: if (Start) begin
        done_d  = 1'b0;
        fail_d  = '0;
        b_d     = '0;
        tap_d   = '0;
        lo_d    = '0;
        hi_d    = '0;
        cnt_d   = '0;
        found_d = 1'b0;
        open_d  = 1'b0;
        state_d = S_RST;
      end
      S_RST: begin
        DlyReset[b_q] = 1'b1;
        cnt_d         = '0;
        state_d       = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          cnt_d   = '0;
          pass_d  = 1'b1;
          state_d = S_SAMPLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_SAMPLE: begin
        pass_d = pass_q & match;
        if (cnt_q == CW'(SAMPLES - 1)) begin
          cnt_d   = '0;
          state_d = S_EVAL;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_EVAL: begin
        state_d = S_STEP;
        // Passes after the first window has closed are deliberately ignored.
        if (pass_q) begin
          if (!found_q) begin
            found_d = 1'b1;
            open_d  = 1'b1;
            lo_d    = tap_q;
            hi_d    = tap_q;
          end else if (open_q) hi_d = tap_q;
        end else if (open_q) begin
          open_d = 1'b0;
`ifdef DQ_CAL_EARLY_EXIT_EN
          state_d = S_CRST;
`endif
        end
      end
      S_STEP: begin
        if (tap_q < TW'(TAPS - 1)) begin
          DlyInc[b_q] = 1'b1;
          tap_d       = tap_q + 1'b1;
          state_d     = S_SETTLE;
        end else state_d = S_CRST;
      end
      S_CRST: begin
        DlyReset[b_q] = 1'b1;
        cnt_d         = '0;
        if (!found_q) begin
          fail_d[b_q] = 1'b1;
          state_d     = S_NEXT;
        end else state_d = S_CINC;
      end
      S_CINC: begin
        if (cnt_q < CW'(c)) begin
          DlyInc[b_q] = 1'b1;
          cnt_d       = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = S_CSETTLE;
        end
      end
      S_CSETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = S_NEXT;
        end else cnt_d = cnt_q + 1'b1;
      end
      S_NEXT: begin
        if (b_q != BW'(WIDTH - 1)) begin
          b_d     = b_q + 1'b1;
          tap_d   = '0;
          lo_d    = '0;
          hi_d    = '0;
          found_d = 1'b0;
          open_d  = 1'b0;
          state_d = S_RST;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK90 or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      tap_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      found_q <= 1'b0;
      open_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      tap_q   <= tap_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      found_q <= found_d;
      open_q  <= open_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

endmodule
